// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage sequencing controller:
// FSM state encoding and sizing of the access timeout counter.
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_DONE   = ST_DONE
  } mem_state_e;

  // Counter must be able to hold values 0..timeout.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_hazard_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose
// destination (other than x0) is a source of the instruction in ID.
module hazard_detect #(
  parameter int RF_SIZE = 5
) (
  input  logic [RF_SIZE-1:0] i_rs1_id,
  input  logic [RF_SIZE-1:0] i_rs2_id,
  input  logic [RF_SIZE-1:0] i_rd_ex,
  input  logic               i_mem_read_ex,
  output logic               o_load_use
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (i_rd_ex != {RF_SIZE{1'b0}});
  assign w_src_match  = (i_rd_ex == i_rs1_id) || (i_rd_ex == i_rs2_id);
  assign o_load_use   = i_mem_read_ex && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencing controller. Runs each data-memory access as a
// req/ready transaction with timeout, freezes the front of the pipeline
// while an access is outstanding, and inserts a one-cycle bubble on a
// load-use hazard once no memory stall is pending.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32,
  parameter int RF_SIZE = 5,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RF_SIZE-1:0] rs1_id,
  input  logic [RF_SIZE-1:0] rs2_id,
  input  logic [RF_SIZE-1:0] rd_ex,
  input  logic               mem_read_ex,
  input  logic               mem_read_mem,
  input  logic               mem_write_mem,
  input  logic [A_WIDTH-1:0] addr_mem,
  input  logic [D_WIDTH-1:0] w_data_mem,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [A_WIDTH-1:0] dmem_addr,
  output logic [D_WIDTH-1:0] dmem_wdata,
  input  logic               dmem_ready,
  input  logic [D_WIDTH-1:0] dmem_rdata,
  output logic               pc_en,
  output logic               if_id_en,
  output logic               ex_mem_en,
  output logic               id_ex_flush,
  output logic               wb_kill,
  output logic [D_WIDTH-1:0] r_data_mem,
  output logic               bus_err
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dmem_req;
  logic               r_dmem_we;
  logic [A_WIDTH-1:0] r_dmem_addr;
  logic [D_WIDTH-1:0] r_dmem_wdata;
  logic [D_WIDTH-1:0] r_rdata;
  logic               r_bus_err;

  logic w_access;
  logic w_load_use;
  logic w_mem_stall;

  assign w_access    = mem_read_mem || mem_write_mem;
  // The detect cycle in IDLE already stalls so the MEM instruction cannot
  // advance before its access has even been issued.
  assign w_mem_stall = ((r_state == S_IDLE) && w_access) || (r_state == S_ACCESS);

  hazard_detect #(
    .RF_SIZE(RF_SIZE)
  ) u_hazard_detect (
    .i_rs1_id     (rs1_id),
    .i_rs2_id     (rs2_id),
    .i_rd_ex      (rd_ex),
    .i_mem_read_ex(mem_read_ex),
    .o_load_use   (w_load_use)
  );

  // Access FSM: issue request, wait for ready or timeout, then release for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= {A_WIDTH{1'b0}};
      r_dmem_wdata <= {D_WIDTH{1'b0}};
      r_rdata      <= {D_WIDTH{1'b0}};
      r_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_state      <= S_ACCESS;
            r_cnt        <= {CNT_W{1'b0}};
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= mem_write_mem;
            r_dmem_addr  <= addr_mem;
            r_dmem_wdata <= w_data_mem;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          // Ready wins over timeout when both land on the last allowed cycle.
          if (dmem_ready) begin
            r_dmem_req <= 1'b0;
            r_cnt      <= {CNT_W{1'b0}};
            r_state    <= S_DONE;
            if (!r_dmem_we) begin
              r_rdata <= dmem_rdata;
            end else begin
              r_rdata <= r_rdata;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_dmem_req <= 1'b0;
            r_bus_err  <= 1'b1;
            r_cnt      <= {CNT_W{1'b0}};
            r_state    <= S_DONE;
            if (!r_dmem_we) begin
              r_rdata <= {D_WIDTH{1'b0}};
            end else begin
              r_rdata <= r_rdata;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // The MEM inputs still describe the finished instruction here,
          // so a new access can only be seen from IDLE.
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_dmem_req <= 1'b0;
          r_cnt      <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Pipeline enable decode: memory stall dominates, then load-use bubble.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    ex_mem_en   = 1'b1;
    id_ex_flush = 1'b0;
    wb_kill     = 1'b0;
    if (w_mem_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      ex_mem_en   = 1'b0;
      id_ex_flush = 1'b0;
      wb_kill     = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      ex_mem_en   = 1'b1;
      id_ex_flush = 1'b1;
      wb_kill     = 1'b0;
    end else begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      ex_mem_en   = 1'b1;
      id_ex_flush = 1'b0;
      wb_kill     = 1'b0;
    end
  end

  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign r_data_mem = r_rdata;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios followed by
// randomized accesses, checked against a transaction-level expectation.
module tb_mem_stage_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_id = 5'd0, rs2_id = 5'd0, rd_ex = 5'd0;
  logic        mem_read_ex = 1'b0, mem_read_mem = 1'b0, mem_write_mem = 1'b0;
  logic [31:0] addr_mem = 32'd0, w_data_mem = 32'd0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        pc_en, if_id_en, ex_mem_en, id_ex_flush, wb_kill;
  logic [31:0] r_data_mem;
  logic        bus_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err   = 1'b0;

  mem_stage_ctrl #(.D_WIDTH(32), .A_WIDTH(32), .RF_SIZE(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .addr_mem(addr_mem), .w_data_mem(w_data_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc_en(pc_en), .if_id_en(if_id_en), .ex_mem_en(ex_mem_en),
    .id_ex_flush(id_ex_flush), .wb_kill(wb_kill),
    .r_data_mem(r_data_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected enables: stall freezes everything, else a hazard inserts a bubble.
  task automatic chk_enables(input string tag, input bit stall, input bit lu);
    chk({tag, ".pc_en"},    {31'd0, pc_en},       {31'd0, !(stall || lu)});
    chk({tag, ".if_id_en"}, {31'd0, if_id_en},    {31'd0, !(stall || lu)});
    chk({tag, ".ex_mem_en"},{31'd0, ex_mem_en},   {31'd0, !stall});
    chk({tag, ".flush"},    {31'd0, id_ex_flush}, {31'd0, (!stall && lu)});
    chk({tag, ".wb_kill"},  {31'd0, wb_kill},     {31'd0, stall});
  endtask

  function automatic bit hazard(input bit mrex, input logic [4:0] rd,
                                input logic [4:0] r1, input logic [4:0] r2);
    return mrex && (rd != 5'd0) && (rd == r1 || rd == r2);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete access. rdy_at in 1..TO is the ACCESS cycle with ready;
  // anything else means the memory never answers.
  task automatic do_access(input string tag, input bit is_load, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int rdy_at, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input bit mrex, input bit noise);
    int  len;
    bit  tmo;
    bit  lu;
    int  n_stall;
    int  n_req;
    tmo = !(rdy_at >= 1 && rdy_at <= TO);
    len = tmo ? TO : rdy_at;
    lu  = hazard(mrex, rd, r1, r2);
    n_stall = 0;
    n_req   = 0;
    rs1_id = r1; rs2_id = r2; rd_ex = rd; mem_read_ex = mrex;
    mem_read_mem = is_load; mem_write_mem = !is_load;
    addr_mem = addr; w_data_mem = wdata;
    for (int k = 0; k <= len + 1; k++) begin
      if (k >= 1 && k == rdy_at) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end else begin
        dmem_ready = noise && (k == 0 || k == len + 1);
        dmem_rdata = $urandom;
      end
      #1;
      if (k == len + 1) begin
        if (is_load) exp_rdata = tmo ? 32'd0 : rdata;
        if (tmo) exp_err = 1'b1;
      end
      chk_enables(tag, (k <= len), lu);
      chk({tag, ".req"},   {31'd0, dmem_req}, {31'd0, (k >= 1 && k <= len)});
      if (k >= 1 && k <= len) begin
        chk({tag, ".we"},    {31'd0, dmem_we}, {31'd0, !is_load});
        chk({tag, ".addr"},  dmem_addr, addr);
        chk({tag, ".wdata"}, dmem_wdata, wdata);
      end
      chk({tag, ".rdata"},   r_data_mem, exp_rdata);
      chk({tag, ".bus_err"}, {31'd0, bus_err}, {31'd0, exp_err});
      if (!pc_en && !ex_mem_en) n_stall++;
      if (dmem_req) n_req++;
      next_cycle();
    end
    chk({tag, ".stall_cycles"}, n_stall, len + 1);
    chk({tag, ".req_cycles"},   n_req,   len);
    // Back to idle with an empty MEM stage.
    mem_read_mem = 1'b0; mem_write_mem = 1'b0; dmem_ready = 1'b0;
    mem_read_ex = 1'b0;
    #1;
    chk({tag, ".idle_req"}, {31'd0, dmem_req}, 32'd0);
    chk_enables({tag, ".idle"}, 1'b0, 1'b0);
    next_cycle();
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst.req", {31'd0, dmem_req}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.rdata", r_data_mem, 32'd0);
    chk("rst.bus_err", {31'd0, bus_err}, 32'd0);
    chk_enables("rst", 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Reset asserted while a load is outstanding.
    mem_read_mem = 1'b1; addr_mem = 32'h200;
    next_cycle();
    next_cycle();
    chk("midrst.req_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.req", {31'd0, dmem_req}, 32'd0);
    chk("midrst.we", {31'd0, dmem_we}, 32'd0);
    chk("midrst.addr", dmem_addr, 32'd0);
    chk("midrst.wdata", dmem_wdata, 32'd0);
    chk("midrst.rdata", r_data_mem, 32'd0);
    chk("midrst.bus_err", {31'd0, bus_err}, 32'd0);
    mem_read_mem = 1'b0; addr_mem = 32'd0;
    #1;
    chk_enables("midrst", 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk_enables("midrst.rel", 1'b0, 1'b0);
    next_cycle();

    // Zero-wait load.
    do_access("ld0", 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    // Store, ready on third ACCESS cycle; read data must stay.
    do_access("st3", 1'b0, 32'h40, 32'h12345678, 32'hFFFF0000, 3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Load-use with no memory access: single bubble; x0 destination: none.
    rd_ex = 5'd5; mem_read_ex = 1'b1; rs1_id = 5'd1; rs2_id = 5'd5;
    #1;
    chk_enables("lu5", 1'b0, 1'b1);
    next_cycle();
    mem_read_ex = 1'b0;
    #1;
    chk_enables("lu5.after", 1'b0, 1'b0);
    next_cycle();
    rd_ex = 5'd0; mem_read_ex = 1'b1; rs1_id = 5'd0; rs2_id = 5'd0;
    #1;
    chk_enables("lu0", 1'b0, 1'b0);
    next_cycle();
    mem_read_ex = 1'b0;

    // Load-use coincident with a memory access: no flush until release.
    do_access("lu_mem", 1'b1, 32'h80, 32'h0, 32'hCAFEF00D, 2, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);

    // Timeout on a load: bus_err set, read data zeroed.
    do_access("tmo", 1'b1, 32'h300, 32'h0, 32'h11111111, 0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    // Ready exactly on the last allowed cycle still completes normally.
    do_access("edge", 1'b1, 32'h304, 32'h0, 32'h5A5A5A5A, TO, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Randomized accesses with random hazards; bus_err must stay sticky.
    for (int t = 0; t < 24; t++) begin
      do_access("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                int'($urandom_range(1, TO + 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
